// File: rtl/gpu_pkg.sv
// Shared opcode, argument-word layout and sequencer state types for the GPU
// command scheduler.
package gpu_pkg;

  typedef enum logic [1:0] {
    OP_FILL      = 2'd0,
    OP_BLIT      = 2'd1,
    OP_RAM_READ  = 2'd2,
    OP_RAM_WRITE = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int X_W    = 9;
  localparam int Y_W    = 8;
  localparam int DATA_W = 8;

  // Field order is MSB first: x1 occupies [58:50], data occupies [7:0].
  typedef struct packed {
    logic [X_W-1:0]    x1;
    logic [Y_W-1:0]    y1;
    logic [X_W-1:0]    x2;
    logic [Y_W-1:0]    y2;
    logic [X_W-1:0]    width;
    logic [Y_W-1:0]    height;
    logic [DATA_W-1:0] data;
  } args_t;

  localparam int ARGS_W = $bits(args_t);

  typedef struct packed {
    op_e   op;
    args_t args;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic [3:0] start_onehot(input op_e op);
    logic [3:0] strobe;
    case (op)
      OP_FILL:      strobe = 4'b0001;
      OP_BLIT:      strobe = 4'b0010;
      OP_RAM_READ:  strobe = 4'b0100;
      OP_RAM_WRITE: strobe = 4'b1000;
      default:      strobe = 4'b0000;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Power-of-two command queue with a registered occupancy count; pushes while
// full and pops while empty are dropped.
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 61
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage write; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_scheduler.sv
// Queues host commands and hands them one at a time to the operations engine,
// strobing a per-opcode start and tracking the engine's busy handshake.
module gpu_cmd_scheduler
  import gpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [ARGS_W-1:0]      cmd_args,
  output logic [ARGS_W-1:0]      gpu_args,
  output logic [3:0]             gpu_start,
  input  logic                   gpu_busy,
  input  logic                   gpu_error,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   idle,
  output logic                   err_sticky,
  input  logic                   err_clear
);

  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  state_e                 state_r;
  logic [3:0]             start_r;
  logic [ARGS_W-1:0]      args_r;
  logic [ACK_W-1:0]       ack_cnt_r;
  logic                   err_r;

  logic [CMD_W-1:0]       fifo_dout_s;
  cmd_t                   head_s;
  logic [$clog2(DEPTH):0] fifo_count_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   push_s;
  logic                   pop_s;

  assign push_s = cmd_valid && !fifo_full_s;
  assign pop_s  = (state_r == ST_IDLE) && !fifo_empty_s;
  assign head_s = fifo_dout_s;

  gpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({cmd_op, cmd_args}),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign cmd_ready   = !fifo_full_s;
  assign queue_count = fifo_count_s;
  assign idle        = fifo_empty_s && (state_r == ST_IDLE);
  assign gpu_start   = start_r;
  assign gpu_args    = args_r;
  assign err_sticky  = err_r;

  // Sequencer: pop into the in-flight register, strobe start, await the engine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      start_r   <= 4'b0000;
      args_r    <= {ARGS_W{1'b0}};
      ack_cnt_r <= {ACK_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_cnt_r <= {ACK_W{1'b0}};
          if (!fifo_empty_s) begin
            args_r  <= head_s.args;
            start_r <= start_onehot(head_s.op);
            state_r <= ST_ISSUE;
          end else begin
            start_r <= 4'b0000;
          end
        end
        ST_ISSUE: begin
          start_r   <= 4'b0000;
          ack_cnt_r <= {ACK_W{1'b0}};
          state_r   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          start_r <= 4'b0000;
          // An engine that never raises busy is treated as having finished.
          if (gpu_busy) begin
            state_r <= ST_WAIT_DONE;
          end else if (ack_cnt_r == ACK_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            ack_cnt_r <= ack_cnt_r + ACK_W'(1'b1);
          end
        end
        ST_WAIT_DONE: begin
          start_r <= 4'b0000;
          if (!gpu_busy) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          start_r <= 4'b0000;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Engine error latch; a new error outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (gpu_error && ((state_r == ST_WAIT_ACK) || (state_r == ST_WAIT_DONE))) begin
      err_r <= 1'b1;
    end else if (err_clear) begin
      err_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Scoreboard bench for gpu_cmd_scheduler: directed scenarios then randomized traffic.
module tb_gpu_cmd_scheduler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [58:0] cmd_args = 59'd0;
  logic [58:0] gpu_args;
  logic [3:0]  gpu_start;
  logic        gpu_busy = 1'b0;
  logic        gpu_error = 1'b0;
  logic [2:0]  queue_count;
  logic        idle;
  logic        err_sticky;
  logic        err_clear = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [60:0] sb[$];
  bit          auto_engine = 1'b0;
  logic [58:0] last_args = 59'd0;
  bit          prev_start = 1'b0;
  logic [60:0] exp_cmd;
  int          resp_mode;

  always #5 clk = ~clk;

  gpu_cmd_scheduler #(.DEPTH(DEPTH), .ACK_TIMEOUT(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_args    (cmd_args),
    .gpu_args    (gpu_args),
    .gpu_start   (gpu_start),
    .gpu_busy    (gpu_busy),
    .gpu_error   (gpu_error),
    .queue_count (queue_count),
    .idle        (idle),
    .err_sticky  (err_sticky),
    .err_clear   (err_clear)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [58:0] pack(input logic [8:0] x1, input logic [7:0] y1,
                                       input logic [8:0] x2, input logic [7:0] y2,
                                       input logic [8:0] w, input logic [7:0] h,
                                       input logic [7:0] d);
    return {x1, y1, x2, y2, w, h, d};
  endfunction

  function automatic logic [58:0] rnd_args();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[58:0];
  endfunction

  // Called just after a falling edge; the push happens on the next rising edge.
  task automatic send(input logic [1:0] op, input logic [58:0] args, input bit exp_acc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_args  = args;
    check("cmd_ready_at_push", cmd_ready, exp_acc);
    if (exp_acc) sb.push_back({op, args});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(idle === 1'b1 && sb.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: still busy after %0d cycles with %0d starts outstanding, required idle", budget, sb.size());
    end
  endtask

  // Monitor: every start strobe is matched against the next expected command.
  always @(negedge clk) begin
    if (reset) begin
      last_args  = 59'd0;
      prev_start = 1'b0;
    end else if (gpu_start != 4'b0000) begin
      check("start_onehot", 64'($countones(gpu_start)), 64'd1);
      check("start_single_cycle", 64'(prev_start), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_start", 64'(gpu_start), 64'd0);
        last_args = gpu_args;
      end else begin
        exp_cmd = sb.pop_front();
        check("start_op", 64'(gpu_start), 64'(4'b0001 << exp_cmd[60:59]));
        check("start_args", 64'(gpu_args), 64'(exp_cmd[58:0]));
        last_args = exp_cmd[58:0];
      end
      prev_start = 1'b1;
    end else begin
      check("args_stable", 64'(gpu_args), 64'(last_args));
      check("ready_vs_count", 64'(cmd_ready), 64'(queue_count < 3'(DEPTH)));
      prev_start = 1'b0;
    end
  end

  // Engine model for random traffic: acknowledge most starts, ignore some.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_engine && gpu_start != 4'b0000) begin
        resp_mode = int'($urandom_range(0, 3));
        if (resp_mode != 0) begin
          repeat ($urandom_range(0, 1)) @(negedge clk);
          gpu_busy = 1'b1;
          repeat ($urandom_range(1, 4)) @(negedge clk);
          gpu_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded 40000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [58:0] a;
    logic [58:0] b;
    logic [1:0]  op;

    // Reset state
    #11;
    check("rst_start", 64'(gpu_start), 64'd0);
    check("rst_args", 64'(gpu_args), 64'd0);
    check("rst_count", 64'(queue_count), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_err", 64'(err_sticky), 64'd0);
    #1 reset = 1'b0;
    @(negedge clk);

    // Single fill: start two cycles after the push
    a = pack(9'd0, 8'd0, 9'd511, 8'd255, 9'd0, 8'd0, 8'd1);
    send(2'd0, a, 1'b1);
    check("lat_no_early_start", 64'(gpu_start), 64'd0);
    check("lat_count_one", 64'(queue_count), 64'd1);
    @(negedge clk);
    check("lat_fill_start", 64'(gpu_start), 64'h1);
    check("lat_fill_args", 64'(gpu_args), 64'(a));
    check("lat_count_zero", 64'(queue_count), 64'd0);
    @(negedge clk);
    check("lat_start_one_cycle", 64'(gpu_start), 64'd0);
    wait_idle(50);

    // Fill the queue while the engine stays busy
    gpu_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(2'(i), rnd_args(), i < 5);
    end
    check("full_count", 64'(queue_count), 64'd4);
    check("full_ready_low", 64'(cmd_ready), 64'd0);
    check("full_one_issued", 64'(sb.size()), 64'd4);
    repeat (3) @(negedge clk);
    check("full_count_held", 64'(queue_count), 64'd4);
    gpu_busy = 1'b0;
    wait_idle(200);

    // Engine never acknowledges a ram_read
    send(2'd2, rnd_args(), 1'b1);
    send(2'd3, rnd_args(), 1'b1);
    check("to_read_start", 64'(gpu_start), 64'h4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("to_quiet_during_wait", 64'(gpu_start), 64'd0);
    end
    @(negedge clk);
    check("to_next_start", 64'(gpu_start), 64'h8);
    check("to_no_error", 64'(err_sticky), 64'd0);
    wait_idle(50);

    // Error during a blit, clear, and same-cycle set/clear
    send(2'd1, rnd_args(), 1'b1);
    @(negedge clk);
    check("err_blit_start", 64'(gpu_start), 64'h2);
    gpu_busy = 1'b1;
    @(negedge clk);
    gpu_error = 1'b1;
    @(negedge clk);
    gpu_error = 1'b0;
    check("err_set", 64'(err_sticky), 64'd1);
    repeat (2) @(negedge clk);
    gpu_busy = 1'b0;
    wait_idle(50);
    check("err_held_in_idle", 64'(err_sticky), 64'd1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("err_cleared", 64'(err_sticky), 64'd0);
    gpu_error = 1'b1;
    @(negedge clk);
    gpu_error = 1'b0;
    check("err_idle_ignored", 64'(err_sticky), 64'd0);
    send(2'd1, rnd_args(), 1'b1);
    @(negedge clk);
    gpu_busy = 1'b1;
    @(negedge clk);
    gpu_error = 1'b1;
    @(negedge clk);
    check("err_set_again", 64'(err_sticky), 64'd1);
    err_clear = 1'b1;
    @(negedge clk);
    gpu_error = 1'b0;
    err_clear = 1'b0;
    check("err_set_beats_clear", 64'(err_sticky), 64'd1);
    gpu_busy = 1'b0;
    wait_idle(50);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("err_cleared_again", 64'(err_sticky), 64'd0);

    // Simultaneous push and pop at count 2
    gpu_busy = 1'b1;
    send(2'd0, rnd_args(), 1'b1);
    b = rnd_args();
    send(2'd3, b, 1'b1);
    send(2'd2, rnd_args(), 1'b1);
    check("pp_count_before", 64'(queue_count), 64'd2);
    @(negedge clk);
    gpu_busy = 1'b0;
    @(negedge clk);
    send(2'd1, rnd_args(), 1'b1);
    check("pp_count_after", 64'(queue_count), 64'd2);
    check("pp_head_start", 64'(gpu_start), 64'h8);
    send(2'd0, rnd_args(), 1'b1);
    send(2'd1, rnd_args(), 1'b1);
    wait_idle(200);

    // Reset while waiting on the engine with two commands queued
    gpu_busy = 1'b1;
    send(2'd1, rnd_args(), 1'b1);
    send(2'd2, rnd_args(), 1'b1);
    send(2'd3, rnd_args(), 1'b1);
    @(negedge clk);
    gpu_error = 1'b1;
    @(negedge clk);
    gpu_error = 1'b0;
    check("mr_count_before", 64'(queue_count), 64'd2);
    check("mr_err_before", 64'(err_sticky), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mr_count", 64'(queue_count), 64'd0);
    check("mr_idle", 64'(idle), 64'd1);
    check("mr_ready", 64'(cmd_ready), 64'd1);
    check("mr_start", 64'(gpu_start), 64'd0);
    check("mr_args", 64'(gpu_args), 64'd0);
    check("mr_err", 64'(err_sticky), 64'd0);
    sb.delete();
    gpu_busy = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mr_no_start_after_release", 64'(gpu_start), 64'd0);
    end
    check("mr_idle_after", 64'(idle), 64'd1);

    // Randomized traffic with a responsive engine model
    auto_engine = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 9) < 6) begin
        op        = 2'($urandom_range(0, 3));
        a         = rnd_args();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_args  = a;
        if (cmd_ready) sb.push_back({op, a});
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_idle(3000);
    auto_engine = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpu_cmd_scheduler.md
GPU_CMD_SCHEDULER -- requirements
Module: gpu_cmd_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 3, meaning cycles to wait for gpu_busy rise after a start pulse.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  host presents a command.
REQ-006 SHALL have port cmd_ready  output  1  FIFO can accept; a push occurs on cycles where cmd_valid & cmd_ready.
REQ-007 SHALL have port cmd_op  input  2  opcode: 0 fill, 1 blit, 2 ram_read, 3 ram_write.
REQ-008 SHALL have port cmd_args  input  59  packed {x1[8:0], y1[7:0], x2[8:0], y2[7:0], width[8:0], height[7:0], data[7:0]}.
REQ-009 SHALL have port gpu_args  output  59  args of the command in flight, same packing; data[0] is the fill value, data is the write byte.
REQ-010 SHALL have port gpu_start  output  4  one-hot start strobes {ram_write, ram_read, blit, fill}.
REQ-011 SHALL have port gpu_busy  input  1  operations engine busy.
REQ-012 SHALL have port gpu_error  input  1  operations engine error flag.
REQ-013 SHALL have port queue_count  output  $clog2(DEPTH)+1  number of queued commands, excluding the one in flight.
REQ-014 SHALL have port idle  output  1  high when the FIFO is empty and the FSM is in IDLE.
REQ-015 SHALL have port err_sticky  output  1  latched engine error.
REQ-016 SHALL have port err_clear  input  1  clears err_sticky.

Function
REQ-017 SHALL hold commands in a FIFO of DEPTH entries; cmd_ready = (count < DEPTH).
REQ-018 SHALL, on a simultaneous push and pop, leave count unchanged and keep order; a push while full SHALL be ignored.
REQ-019 SHALL wrap read/write pointers modulo DEPTH.
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-021 SHALL, in IDLE with a non-empty FIFO, pop the head into the in-flight register and go to ISSUE on the next cycle.
REQ-022 SHALL, in ISSUE, assert exactly one gpu_start bit (selected by opcode) for exactly one cycle, then go to WAIT_ACK.
REQ-023 SHALL hold gpu_args stable from ISSUE until the FSM returns to IDLE.
REQ-024 SHALL, in WAIT_ACK, go to WAIT_DONE when gpu_busy=1, or to IDLE once ACK_TIMEOUT cycles pass with gpu_busy=0, treating the command as complete.
REQ-025 SHALL, in WAIT_DONE, return to IDLE on the first cycle gpu_busy=0.
REQ-026 SHALL issue commands no faster than one per 3 cycles (IDLE, ISSUE, WAIT_ACK minimum), giving a start latency of 2 cycles from a push into an empty, idle block.
REQ-027 SHALL set err_sticky on any cycle with gpu_error=1 in WAIT_ACK or WAIT_DONE; err_clear SHALL clear it, with set taking priority when both occur on the same cycle.
REQ-028 SHALL not stall, flush, or retry on error; queued commands continue to issue.
REQ-029 SHALL ignore gpu_busy in IDLE and ISSUE.

Reset
REQ-030 SHALL, on reset assertion and independent of clk, empty the FIFO, set the FSM to IDLE, and drive gpu_start=0, gpu_args=0, err_sticky=0, queue_count=0, idle=1, cmd_ready=1.
REQ-031 SHALL discard any command in flight on reset mid-operation, with no start pulse on the cycle after release.

Structure
REQ-032 SHALL place the opcode enum, the field widths/offsets of the 59-bit argument word, and the FSM state encoding in shared package gpu_pkg.
REQ-033 SHALL instantiate one sub-module, gpu_cmd_fifo (parameterised DEPTH, width 61), for the queue.

Verification
REQ-034 SHALL cover: push fill(x1=0,y1=0,x2=511,y2=255,data=1) into an idle block -> gpu_start=4'b0001 for one cycle, 2 cycles after the push; gpu_args equal to the pushed args.
REQ-035 SHALL cover: push 5 commands with DEPTH=4 while gpu_busy is held at 1 -> the first issues; 4 are queued; cmd_ready=0; the 6th push is ignored; issue order is preserved after busy falls.
REQ-036 SHALL cover: gpu_busy never rises after a ram_read start -> return to IDLE after 3 WAIT_ACK cycles; the next command's start follows with no error.
REQ-037 SHALL cover: gpu_error pulsed during a blit -> err_sticky=1 until err_clear; err_clear and gpu_error on the same cycle -> err_sticky stays 1.
REQ-038 SHALL cover: reset asserted in WAIT_DONE with 2 queued commands -> queue_count=0, idle=1 immediately; no gpu_start after release.
REQ-039 SHALL cover: simultaneous push and pop at count=2 -> count stays 2; FIFO data order intact across pointer wrap.
